// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: ULA opcodes, forwarding selects, ID/EX bundle.
// XLEN/RW are the datapath and register-index widths.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [3:0] ULA_ADD  = 4'b0000;
    localparam logic [3:0] ULA_SUB  = 4'b0001;
    localparam logic [3:0] ULA_XOR  = 4'b0010;
    localparam logic [3:0] ULA_OR   = 4'b0011;
    localparam logic [3:0] ULA_AND  = 4'b0100;
    localparam logic [3:0] ULA_SLL  = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_SLT  = 4'b1000;
    localparam logic [3:0] ULA_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [3:0]      ula_op;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// Operand forwarding select for one source register (MEM beats WB, x0 never).
// Network present only when EX_FWD_EN is defined; otherwise passes reg data.
module ex_fwd_mux
    import rv32_pkg::*;
(
    input  logic [RW-1:0]   rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [RW-1:0]   mem_rd_i,
    input  logic            mem_reg_write_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic [RW-1:0]   wb_rd_i,
    input  logic            wb_reg_write_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic [XLEN-1:0] data_o
);

    fwd_sel_t sel;

`ifdef EX_FWD_EN
    // pick the youngest in-flight producer of rs
    always_comb begin
        sel = FWD_REG;
        if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i))
            sel = FWD_MEM;
        else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i))
            sel = FWD_WB;
    end
`else
    logic unused_fwd;
    assign sel = FWD_REG;
    assign unused_fwd = ^{rs_i, mem_rd_i, mem_reg_write_i, mem_result_i,
                          wb_rd_i, wb_reg_write_i, wb_result_i};
`endif

    // route the selected source onto the operand
    always_comb begin
        data_o = reg_data_i;
        unique case (sel)
            FWD_MEM: data_o = mem_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select and hazard detection.
// EX_FWD_EN: forwarding + load-use bubble; undefined: full RAW stall.
module id_ex_stage
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [3:0]      id_ula_op,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [RW-1:0]   mem_rd,
    input  logic [RW-1:0]   wb_rd,
    input  logic            mem_reg_write,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] ex_A,
    output logic [XLEN-1:0] ex_B,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      ex_ula_op,
    output logic [RW-1:0]   ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_valid,
    output logic            load_use_stall
);

    id_ex_t          ex_q, ex_d, id_in;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // gather the decode slot into one bundle
    always_comb begin
        id_in           = '0;
        id_in.valid     = id_valid;
        id_in.pc        = id_pc;
        id_in.rs1_data  = id_rs1_data;
        id_in.rs2_data  = id_rs2_data;
        id_in.imm       = id_imm;
        id_in.rs1       = id_rs1;
        id_in.rs2       = id_rs2;
        id_in.rd        = id_rd;
        id_in.ula_op    = id_ula_op;
        id_in.src_a_pc  = id_src_a_pc;
        id_in.src_b_imm = id_src_b_imm;
        id_in.reg_write = id_reg_write;
        id_in.mem_read  = id_mem_read;
        id_in.mem_write = id_mem_write;
    end

`ifdef EX_FWD_EN
    assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
                          & id_valid
                          & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
`else
    logic ex_hit, mem_hit;
    assign ex_hit  = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0)
                   & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    assign mem_hit = mem_reg_write & (mem_rd != '0)
                   & ((mem_rd == id_rs1) | (mem_rd == id_rs2));
    assign load_use_stall = ex_hit | mem_hit;
`endif

    // flush beats stall beats hazard bubble beats normal capture
    always_comb begin
        ex_d = id_in;
        priority case (1'b1)
            flush:          ex_d = '0;
            stall:          ex_d = ex_q;
            load_use_stall: ex_d = '0;
            default:        ex_d = id_in;
        endcase
    end

    // ID/EX register
    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    ex_fwd_mux u_fwd_rs1 (
        .rs_i            (ex_q.rs1),
        .reg_data_i      (ex_q.rs1_data),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (fwd_rs1)
    );

    ex_fwd_mux u_fwd_rs2 (
        .rs_i            (ex_q.rs2),
        .reg_data_i      (ex_q.rs2_data),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_result_i    (mem_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .data_o          (fwd_rs2)
    );

    assign ex_A          = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
    assign ex_B          = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_ula_op     = ex_q.ula_op;
    assign ex_rd         = ex_q.rd;
    assign ex_pc         = ex_q.pc;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
// Expectations follow EX_FWD_EN when the bench is built with it.
module tb_id_ex_stage;
    import rv32_pkg::*;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_ula_op;
    logic id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] ex_A, ex_B, ex_store_data, ex_pc;
    logic [3:0]  ex_ula_op;
    logic [4:0]  ex_rd;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, load_use_stall;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ula_op(id_ula_op), .id_src_a_pc(id_src_a_pc),
        .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_result(mem_result), .wb_result(wb_result),
        .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data),
        .ex_ula_op(ex_ula_op), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_valid(ex_valid),
        .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic flush, stall, vld;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] op;
        logic sa, sb, rw, mr, mw;
        logic [4:0] mrd, wrd;
        logic mrw, wrw;
        logic [31:0] mres, wres;
        logic [31:0] eA, eB, eS;
        logic [3:0] eop;
        logic [4:0] erd;
        logic ev, erw, emr, elus;
    } vec_t;

    function automatic vec_t iv(logic vld, logic [31:0] pc, r1d, r2d, imm,
                                logic [4:0] rs1, rs2, rd, logic [3:0] op,
                                logic sa, sb, rw, mr, mw);
        vec_t x;
        x = '{default: '0};
        x.vld = vld; x.pc = pc; x.r1d = r1d; x.r2d = r2d; x.imm = imm;
        x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.op = op;
        x.sa = sa; x.sb = sb; x.rw = rw; x.mr = mr; x.mw = mw;
        return x;
    endfunction

    function automatic vec_t idle();
        return iv(0, 0, 0, 0, 0, 0, 0, 0, ULA_ADD, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t fw(vec_t x, logic [4:0] mrd, logic mrw,
                                logic [31:0] mres, logic [4:0] wrd,
                                logic wrw, logic [31:0] wres);
        vec_t y = x;
        y.mrd = mrd; y.mrw = mrw; y.mres = mres;
        y.wrd = wrd; y.wrw = wrw; y.wres = wres;
        return y;
    endfunction

    function automatic vec_t xp(vec_t x, logic [31:0] a, b, s,
                                logic [3:0] op, logic [4:0] rd,
                                logic v, rw, mr, lus);
        vec_t y = x;
        y.eA = a; y.eB = b; y.eS = s; y.eop = op; y.erd = rd;
        y.ev = v; y.erw = rw; y.emr = mr; y.elus = lus;
        return y;
    endfunction

    task automatic drive(vec_t x);
        flush = x.flush; stall = x.stall; id_valid = x.vld;
        id_pc = x.pc; id_rs1_data = x.r1d; id_rs2_data = x.r2d;
        id_imm = x.imm; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
        id_ula_op = x.op; id_src_a_pc = x.sa; id_src_b_imm = x.sb;
        id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw;
        mem_rd = x.mrd; mem_reg_write = x.mrw; mem_result = x.mres;
        wb_rd = x.wrd; wb_reg_write = x.wrw; wb_result = x.wres;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    vec_t tbl[13];
    vec_t h;

    initial begin
        // fill the vector table
        tbl[0]  = xp(iv(1, 'h10, 5, 7, 0, 1, 2, 3, ULA_ADD, 0, 0, 1, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = xp(iv(1, 'h14, 'h33, 5, 0, 3, 1, 4, ULA_SUB, 0, 0, 1, 0, 0),
                     5, 7, 7, ULA_ADD, 3, 1, 1, 0, !FWD);
        tbl[2]  = xp(fw(idle(), 3, 1, 12, 0, 0, 0),
                     FWD ? 12 : 0, FWD ? 5 : 0, FWD ? 5 : 0,
                     FWD ? ULA_SUB : ULA_ADD, FWD ? 4 : 0, FWD, FWD, 0, 0);
        tbl[3]  = xp(iv(1, 'h18, 'h60, 'h99, 4, 6, 0, 7, ULA_XOR, 0, 1, 1, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = xp(fw(iv(1, 'h1C, 'h61, 'h98, 8, 0, 0, 8, ULA_OR, 0, 1, 1, 0, 0),
                        6, 1, 'hAA, 6, 1, 'hBB),
                     FWD ? 'hAA : 'h60, 4, 'h99, ULA_XOR, 7, 1, 1, 0, 0);
        tbl[5]  = xp(fw(iv(1, 'h20, 'h90, 'hA0, 0, 9, 10, 11, ULA_AND, 0, 0, 1, 0, 0),
                        0, 1, 'hAA, 0, 1, 'hBB),
                     'h61, 8, 'h98, ULA_OR, 8, 1, 1, 0, 0);
        tbl[6]  = xp(fw(iv(1, 'h24, 'hC0, 'hC1, 0, 12, 12, 13, ULA_SLT, 0, 0, 1, 0, 0),
                        10, 1, 'h111, 9, 1, 'h222),
                     FWD ? 'h222 : 'h90, FWD ? 'h111 : 'hA0, FWD ? 'h111 : 'hA0,
                     ULA_AND, 11, 1, 1, 0, 0);
        tbl[7]  = xp(fw(iv(1, 'h100, 5, 6, 'h2000, 0, 0, 14, ULA_ADD, 1, 1, 1, 0, 0),
                        12, 0, 'h333, 12, 1, 'h444),
                     FWD ? 'h444 : 'hC0, FWD ? 'h444 : 'hC1, FWD ? 'h444 : 'hC1,
                     ULA_SLT, 13, 1, 1, 0, 0);
        tbl[8]  = xp(iv(1, 'h28, 'h1000, 0, 4, 2, 0, 5, ULA_ADD, 0, 1, 1, 1, 0),
                     'h100, 'h2000, 6, ULA_ADD, 14, 1, 1, 0, 0);
        tbl[9]  = xp(iv(1, 'h2C, 'h11, 'h55, 0, 1, 5, 6, ULA_ADD, 0, 0, 1, 0, 0),
                     'h1000, 4, 0, ULA_ADD, 5, 1, 1, 1, 1);
        tbl[10] = xp(fw(iv(1, 'h2C, 'h11, 'h55, 0, 1, 5, 6, ULA_ADD, 0, 0, 1, 0, 0),
                        5, 1, 'h5AD, 0, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, !FWD);
        tbl[11] = xp(fw(idle(), 0, 0, 0, 5, 1, 'h5AD),
                     FWD ? 'h11 : 0, FWD ? 'h5AD : 0, FWD ? 'h5AD : 0,
                     ULA_ADD, FWD ? 6 : 0, FWD, FWD, 0, 0);
        tbl[12] = xp(idle(), 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset held two clocks with a live decode slot
        rst_n = 1'b0;
        drive(iv(1, 'hDEAD, 'h1, 'h2, 'h3, 1, 2, 3, ULA_SRA, 1, 1, 1, 1, 1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst ex_valid", {31'b0, ex_valid}, 0);
        chk("rst ex_ula_op", {28'b0, ex_ula_op}, 0);
        chk("rst ex_reg_write", {31'b0, ex_reg_write}, 0);
        chk("rst ex_mem_read", {31'b0, ex_mem_read}, 0);
        chk("rst ex_mem_write", {31'b0, ex_mem_write}, 0);
        chk("rst ex_A", ex_A, 0);
        chk("rst ex_B", ex_B, 0);
        chk("rst ex_store_data", ex_store_data, 0);
        chk("rst ex_pc", ex_pc, 0);
        chk("rst ex_rd", {27'b0, ex_rd}, 0);
        chk("rst load_use_stall", {31'b0, load_use_stall}, 0);
        rst_n = 1'b1;
        drive(idle());

        // per-cycle table: drive at negedge, check EX outputs for this cycle
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d ex_A", i), ex_A, tbl[i].eA);
            chk($sformatf("row%0d ex_B", i), ex_B, tbl[i].eB);
            chk($sformatf("row%0d ex_store_data", i), ex_store_data, tbl[i].eS);
            chk($sformatf("row%0d ex_ula_op", i), {28'b0, ex_ula_op}, {28'b0, tbl[i].eop});
            chk($sformatf("row%0d ex_rd", i), {27'b0, ex_rd}, {27'b0, tbl[i].erd});
            chk($sformatf("row%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d ex_reg_write", i), {31'b0, ex_reg_write}, {31'b0, tbl[i].erw});
            chk($sformatf("row%0d ex_mem_read", i), {31'b0, ex_mem_read}, {31'b0, tbl[i].emr});
            chk($sformatf("row%0d load_use_stall", i), {31'b0, load_use_stall}, {31'b0, tbl[i].elus});
        end

        // stall hold: load a store, then freeze three cycles with ID churning
        @(negedge clk);
        drive(iv(1, 'h40, 'h111, 'h222, 0, 1, 2, 3, ULA_XOR, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            h = iv(1, 'h50 + k, k, k + 1, k + 2, 5'(k + 20), 5'(k + 21),
                   5'(k + 22), ULA_SLL, 1, 1, 1, 1, 0);
            h.stall = 1'b1;
            drive(h);
            #1;
            chk($sformatf("stall%0d ex_A", k), ex_A, 'h111);
            chk($sformatf("stall%0d ex_B", k), ex_B, 'h222);
            chk($sformatf("stall%0d ex_pc", k), ex_pc, 'h40);
            chk($sformatf("stall%0d ex_rd", k), {27'b0, ex_rd}, 3);
            chk($sformatf("stall%0d ex_ula_op", k), {28'b0, ex_ula_op}, {28'b0, ULA_XOR});
            chk($sformatf("stall%0d ex_mem_write", k), {31'b0, ex_mem_write}, 1);
            chk($sformatf("stall%0d ex_valid", k), {31'b0, ex_valid}, 1);
        end
        // forwarding stays live while frozen
        mem_rd = 5'd1; mem_reg_write = 1'b1; mem_result = 32'hF00D;
        wb_rd = 5'd2; wb_reg_write = 1'b1; wb_result = 32'hBEEF;
        #1;
        chk("stall fwd ex_A", ex_A, FWD ? 32'hF00D : 32'h111);
        chk("stall fwd ex_store_data", ex_store_data, FWD ? 32'hBEEF : 32'h222);
        // flush together with stall still produces a bubble
        @(negedge clk);
        flush = 1'b1;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        #1;
        chk("held before flush ex_valid", {31'b0, ex_valid}, 1);
        @(negedge clk);
        drive(idle());
        #1;
        chk("flush ex_valid", {31'b0, ex_valid}, 0);
        chk("flush ex_A", ex_A, 0);
        chk("flush ex_pc", ex_pc, 0);
        chk("flush ex_rd", {27'b0, ex_rd}, 0);
        chk("flush ex_mem_write", {31'b0, ex_mem_write}, 0);

        // flush beats a pending hazard: load in EX, consumer in ID, flush
        drive(iv(1, 'h60, 'h7, 0, 0, 1, 0, 9, ULA_ADD, 0, 1, 1, 1, 0));
        @(negedge clk);
        drive(iv(1, 'h64, 'h3, 'h4, 0, 9, 0, 10, ULA_SUB, 0, 0, 1, 0, 0));
        #1;
        chk("hazard load_use_stall", {31'b0, load_use_stall}, 1);
        flush = 1'b1;
        @(negedge clk);
        drive(idle());
        #1;
        chk("flush+hazard ex_valid", {31'b0, ex_valid}, 0);
        chk("flush+hazard load_use_stall", {31'b0, load_use_stall}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
